// File: rtl/sd_fetch_scheduler_if.sv
// sd_fetch_scheduler_if: block-read handshake between the fetch scheduler and the SPI read engine.
interface sd_fetch_scheduler_if;
   logic        rd_start;
   logic [31:0] rd_addr;
   logic        rd_target;
   logic        rd_busy;
   logic        rd_done;
   logic        rd_err;
   modport master (output rd_start, rd_addr, rd_target, input rd_busy, rd_done, rd_err);
   modport slave  (input rd_start, rd_addr, rd_target, output rd_busy, rd_done, rd_err);
endinterface

// File: rtl/sd_fetch_scheduler.sv
// sd_fetch_scheduler: arbitrates SD block reads between the idle video bank and the audio FIFO.
module sd_fetch_scheduler #(
   parameter int          VID_BLOCKS = 118,
   parameter logic [31:0] VID_BASE   = 32'd0,
   parameter logic [31:0] AUD_BASE   = 32'h0010_0000,
   parameter int          AUD_DEPTH  = 2048,
   parameter int          AUD_LOW_WM = 768,
   parameter int          MAX_RETRY  = 3
) (
   input  logic                 CLK_40,
   input  logic                 reset,
   input  logic                 frame_req,
   input  logic [11:0]          aud_level,
   sd_fetch_scheduler_if.master rd,
   output logic                 video_data_ready,
   output logic                 frame_overrun,
   output logic                 fault
);
   localparam int CW = $clog2(VID_BLOCKS + 1);
   localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
   localparam int THR = AUD_LOW_WM < AUD_DEPTH - 512 ? AUD_LOW_WM : AUD_DEPTH - 512;
   localparam logic [11:0] AUD_THR = 12'(THR);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_t;
   state_t state, state_n;
   logic [31:0] vid_ptr, aud_ptr;
   logic [CW-1:0] vid_cnt;
   logic [RW-1:0] retry;
   logic pend, vid_active, last_aud, target;
   logic aud_need, vid_wait, grant_aud, grant_vid, pick, new_frame, blk_done, blk_err, retry_ok;
   // A queued frame counts as waiting video so audio cannot take back-to-back grants ahead of it.
   always_comb begin
      aud_need  = aud_level <= AUD_THR;
      vid_wait  = vid_active | pend;
      grant_aud = aud_need & ~(last_aud & vid_wait);
      grant_vid = ~grant_aud & vid_wait;
      pick      = (state == IDLE) & ~rd.rd_busy & (grant_aud | grant_vid);
      new_frame = pick & grant_vid & ~vid_active;
      blk_err   = (state == WAIT) & rd.rd_err;
      blk_done  = (state == WAIT) & rd.rd_done & ~rd.rd_err;
      retry_ok  = retry < RW'(MAX_RETRY);
      state_n   = state;
      state_n   = state == IDLE  ? (pick ? ISSUE : IDLE) :
                  state == ISSUE ? WAIT :
                  state == WAIT  ? (blk_err ? (retry_ok ? ISSUE : FAULT) : blk_done ? IDLE : WAIT) :
                  FAULT;
   end
   assign rd.rd_start  = state == ISSUE;
   assign rd.rd_addr   = rd.rd_start ? (target ? aud_ptr : vid_ptr) : '0;
   assign rd.rd_target = target;
   always_ff @(posedge CLK_40 or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge CLK_40 or posedge reset)
      if (reset) begin
         vid_ptr          <= VID_BASE;
         aud_ptr          <= AUD_BASE;
         vid_cnt          <= '0;
         retry            <= '0;
         pend             <= 1'b0;
         vid_active       <= 1'b0;
         last_aud         <= 1'b0;
         target           <= 1'b0;
         video_data_ready <= 1'b0;
         frame_overrun    <= 1'b0;
         fault            <= 1'b0;
      end else begin
         video_data_ready <= 1'b0;
         pend             <= frame_req | (pend & ~new_frame);
         frame_overrun    <= frame_overrun | (frame_req & pend & vid_active);
         fault            <= fault | (blk_err & ~retry_ok);
         if (pick) target <= grant_aud;
         if (new_frame) begin
            vid_active <= 1'b1;
            vid_cnt    <= '0;
         end
         if (blk_err && retry_ok) retry <= retry + 1'b1;
         if (blk_done) begin
            retry    <= '0;
            last_aud <= target;
            if (target) aud_ptr <= aud_ptr + 32'd1;
            else begin
               vid_ptr <= vid_ptr + 32'd1;
               vid_cnt <= vid_cnt + 1'b1;
               if (vid_cnt == CW'(VID_BLOCKS - 1)) begin
                  video_data_ready <= 1'b1;
                  vid_active       <= 1'b0;
               end
            end
         end
      end
endmodule

// File: tb/tb_sd_fetch_scheduler.sv
// tb_sd_fetch_scheduler: randomized engine responder with a transaction-level scoreboard.
module tb_sd_fetch_scheduler;
   typedef struct packed {logic tgt; logic [31:0] addr;} exp_t;
   logic        CLK_40 = 1'b0;
   logic        reset = 1'b1;
   logic        frame_req = 1'b0;
   logic [11:0] aud_level = 12'd2000;
   logic        video_data_ready, frame_overrun, fault;
   sd_fetch_scheduler_if bus();
   sd_fetch_scheduler dut (
      .CLK_40(CLK_40), .reset(reset), .frame_req(frame_req), .aud_level(aud_level),
      .rd(bus), .video_data_ready(video_data_ready), .frame_overrun(frame_overrun), .fault(fault)
   );
   always #5 CLK_40 = ~CLK_40;
   int vectors = 0, miscompares = 0;
   exp_t q[$];
   logic [31:0] m_vid, m_aud;
   int m_cnt, m_retry, vdr_exp;
   bit m_pend, m_active, m_last_aud, m_busy, m_fault, m_overrun, m_tgt;
   bit aud_rand = 0, allow_err = 0, force_err = 0;
   int fr_burst = 0;
   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction
   function automatic void m_reset();
      m_vid = 32'd0; m_aud = 32'h0010_0000; m_cnt = 0; m_retry = 0; vdr_exp = 0;
      m_pend = 0; m_active = 0; m_last_aud = 0; m_busy = 0; m_fault = 0; m_overrun = 0; m_tgt = 0;
      q.delete();
   endfunction
   // Decide the next grant from the arbitration rules and queue the read it must produce.
   function automatic void m_pick();
      bit need = aud_level <= 12'd768;
      bit vwait = m_active || m_pend;
      m_busy = 1'b0;
      if (m_fault) return;
      if (need && !(m_last_aud && vwait)) begin
         m_tgt = 1'b1; q.push_back({1'b1, m_aud}); m_busy = 1'b1;
      end else if (vwait) begin
         if (!m_active) begin m_active = 1'b1; m_pend = 1'b0; m_cnt = 0; end
         m_tgt = 1'b0; q.push_back({1'b0, m_vid}); m_busy = 1'b1;
      end
   endfunction
   function automatic void m_frame_req();
      if (m_pend && m_active) m_overrun = 1'b1;
      else m_pend = 1'b1;
      if (!m_busy) m_pick();
   endfunction
   function automatic void m_complete(bit ok);
      if (ok) begin
         if (m_tgt) m_aud = m_aud + 32'd1;
         else begin
            m_vid = m_vid + 32'd1;
            m_cnt++;
            if (m_cnt == 118) begin m_active = 1'b0; vdr_exp++; end
         end
         m_retry = 0;
         m_last_aud = m_tgt;
         if (aud_rand) aud_level = 12'($urandom_range(0, 2047));
         else if (!m_active && !m_pend) aud_level = 12'd2000;
         m_pick();
      end else if (m_retry < 3) begin
         m_retry++;
         q.push_back({m_tgt, m_tgt ? m_aud : m_vid});
      end else begin
         m_fault = 1'b1; m_busy = 1'b0;
      end
   endfunction
   initial begin
      int d, consec;
      bit e, aborted;
      consec = 0;
      bus.rd_busy = 1'b0; bus.rd_done = 1'b0; bus.rd_err = 1'b0;
      forever begin
         @(negedge CLK_40);
         bus.rd_done = 1'b0; bus.rd_err = 1'b0;
         if (bus.rd_start && !reset) begin
            bus.rd_busy = 1'b1;
            d = int'($urandom_range(2, 6));
            aborted = 1'b0;
            for (int i = 0; i < d && !aborted; i++) begin
               @(negedge CLK_40);
               frame_req = 1'b0;
               if (reset) aborted = 1'b1;
               else if (i == 0 && fr_burst > 0) begin frame_req = 1'b1; fr_burst--; m_frame_req(); end
            end
            if (aborted) bus.rd_busy = 1'b0;
            else begin
               e = force_err || (allow_err && consec < 3 && $urandom_range(0, 5) == 0);
               check("target_hold", bus.rd_target, m_tgt);
               bus.rd_err = e;
               bus.rd_done = !e || $urandom_range(0, 1) == 1;
               consec = e ? consec + 1 : 0;
               bus.rd_busy = 1'b0;
               m_complete(!e);
            end
         end
      end
   end
   initial begin
      exp_t x;
      forever begin
         @(negedge CLK_40);
         if (!reset) begin
            if (bus.rd_start) begin
               if (q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL unexpected_start: got addr 0x%0h target %0d, expected no start", bus.rd_addr, bus.rd_target);
               end else begin
                  x = q.pop_front();
                  check("rd_target", bus.rd_target, x.tgt);
                  check("rd_addr", bus.rd_addr, x.addr);
               end
            end
            if (video_data_ready) begin
               check("video_data_ready", vdr_exp > 0, 1);
               if (vdr_exp > 0) vdr_exp--;
            end
         end
      end
   end
   task automatic set_aud(input logic [11:0] v);
      aud_level = v;
      if (!m_busy) m_pick();
   endtask
   task automatic pulse_frame_req();
      frame_req = 1'b1;
      m_frame_req();
      @(negedge CLK_40);
      frame_req = 1'b0;
   endtask
   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge CLK_40);
         ok = !m_busy && q.size() == 0 && !bus.rd_busy && !bus.rd_done && !bus.rd_err;
      end
      check("idle_reached", ok, 1);
      repeat (4) @(negedge CLK_40);
   endtask
   task automatic end_checks();
      check("pending_vdr", vdr_exp, 0);
      check("pending_reads", q.size(), 0);
      check("frame_overrun", frame_overrun, m_overrun);
      check("fault", fault, m_fault);
   endtask
   task automatic check_zero(string tag);
      check({tag, "_rd_start"}, bus.rd_start, 0);
      check({tag, "_rd_addr"}, bus.rd_addr, 0);
      check({tag, "_rd_target"}, bus.rd_target, 0);
      check({tag, "_vdr"}, video_data_ready, 0);
      check({tag, "_overrun"}, frame_overrun, 0);
      check({tag, "_fault"}, fault, 0);
   endtask
   initial begin
      bit seen;
      m_reset();
      repeat (3) @(negedge CLK_40);
      check_zero("reset");
      reset = 1'b0;
      @(negedge CLK_40);
      set_aud(12'($urandom_range(769, 4095)));
      pulse_frame_req();
      wait_idle();
      end_checks();
      set_aud(12'($urandom_range(0, 768)));
      pulse_frame_req();
      wait_idle();
      end_checks();
      allow_err = 1'b1;
      set_aud(12'd2000);
      pulse_frame_req();
      fr_burst = 3;
      wait_idle();
      end_checks();
      aud_rand = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_aud(12'($urandom_range(0, 2047)));
         pulse_frame_req();
         fr_burst = int'($urandom_range(0, 2));
         wait_idle();
         end_checks();
      end
      set_aud(12'($urandom_range(0, 768)));
      wait_idle();
      end_checks();
      aud_rand = 1'b0;
      allow_err = 1'b0;
      set_aud(12'd100);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge CLK_40);
         seen = bus.rd_start;
      end
      check("start_before_reset", seen, 1);
      @(negedge CLK_40);
      #3 reset = 1'b1;
      #1 check_zero("async_reset");
      m_reset();
      aud_level = 12'd2000;
      repeat (2) @(negedge CLK_40);
      reset = 1'b0;
      @(negedge CLK_40);
      pulse_frame_req();
      wait_idle();
      end_checks();
      force_err = 1'b1;
      pulse_frame_req();
      wait_idle();
      repeat (30) @(negedge CLK_40);
      pulse_frame_req();
      repeat (30) @(negedge CLK_40);
      end_checks();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
endmodule
